// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared operation/state encodings and default operand width for the ALU sequencer
package alu_seq_pkg;
  localparam int DEF_N = 16;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_CMP} alu_op_e;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} seq_state_e;
endpackage

// File: rtl/alu_sequencer_mul.sv
// mul_iter: N-step LSB-first shift-add multiplier; start loads a/b, done flags the last step, product is that step's sum
//   clk, rst_n (async active-low), start, a[N], b[N] -> done, product[2N]
import alu_seq_pkg::*;
module mul_iter #(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CNT_W = $clog2(N) + 1;
  logic [2*N-1:0] acc, mcand;
  logic [N-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic run;
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done = run && cnt == CNT_W'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      acc <= '0;
      mcand <= {{N{1'b0}}, a};
      mplier <= b;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      acc <= product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: execution-stage controller running ADD/SUB/CMP in one step and MUL via mul_iter, valid/ready on both sides
//   req_valid/req_ready/req_op/req_rs1/req_rs2 in; rsp_valid/rsp_ready/rsp_rd/rsp_co/rsp_eq/rsp_gt/rsp_lt out; busy
import alu_seq_pkg::*;
module alu_sequencer #(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [N-1:0]   req_rs1,
  input  logic [N-1:0]   req_rs2,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_rd,
  output logic           rsp_co,
  output logic           rsp_eq,
  output logic           rsp_gt,
  output logic           rsp_lt,
  output logic           busy
);
  seq_state_e state;
  alu_op_e op_q;
  logic [N-1:0] a_q, b_q;
  logic [N:0] sum, diff;
  logic mul_start, mul_done;
  logic [2*N-1:0] product;
  assign req_ready = state == IDLE;
  assign mul_start = req_valid && req_ready && alu_op_e'(req_op) == OP_MUL;
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  // the extra top bit of the widened difference is the borrow, i.e. a_q < b_q
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  mul_iter #(.N(N)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(mul_start),
    .a(req_rs1),
    .b(req_rs2),
    .done(mul_done),
    .product(product)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op_q <= OP_ADD;
      a_q <= '0;
      b_q <= '0;
      rsp_valid <= 1'b0;
      rsp_rd <= '0;
      rsp_co <= 1'b0;
      rsp_eq <= 1'b0;
      rsp_gt <= 1'b0;
      rsp_lt <= 1'b0;
      busy <= 1'b0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          op_q <= alu_op_e'(req_op);
          a_q <= req_rs1;
          b_q <= req_rs2;
          busy <= 1'b1;
          state <= alu_op_e'(req_op) == OP_MUL ? MUL : EXEC;
        end
        EXEC: begin
          rsp_rd <= op_q == OP_ADD ? {{N{1'b0}}, sum[N-1:0]} : op_q == OP_SUB ? {{N{1'b0}}, diff[N-1:0]} : '0;
          rsp_co <= op_q == OP_ADD ? sum[N] : op_q == OP_SUB && diff[N];
          rsp_eq <= op_q == OP_CMP && a_q == b_q;
          rsp_gt <= op_q == OP_CMP && a_q > b_q;
          rsp_lt <= op_q == OP_CMP && a_q < b_q;
          rsp_valid <= 1'b1;
          state <= DONE;
        end
        MUL: if (mul_done) begin
          rsp_rd <= product;
          rsp_co <= 1'b0;
          rsp_eq <= 1'b0;
          rsp_gt <= 1'b0;
          rsp_lt <= 1'b0;
          rsp_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer
import alu_seq_pkg::*;
module tb_alu_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, rsp_ready = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [15:0] req_rs1 = '0, req_rs2 = '0;
  logic req_ready, rsp_valid, rsp_co, rsp_eq, rsp_gt, rsp_lt, busy;
  logic [31:0] rsp_rd;
  int checks = 0, errors = 0;
  int cyc;
  logic busy_ok;
  alu_sequencer #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_co(rsp_co), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    chk("req_ready_before_send", req_ready, 1'b1);
    req_valid = 1'b1;
    req_op = op;
    req_rs1 = a;
    req_rs2 = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'b11;
    req_rs1 = 16'hDEAD;
    req_rs2 = 16'hBEEF;
  endtask
  task automatic wait_rsp(output int c, output logic bz);
    c = 1;
    bz = busy;
    while (!rsp_valid && c < 100) begin
      @(negedge clk);
      c++;
      bz = bz & busy;
    end
  endtask
  task automatic take;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("valid_after_take", rsp_valid, 1'b0);
    chk("ready_after_take", req_ready, 1'b1);
  endtask
  task automatic op_check(input string tag, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int lat, input logic [31:0] rd, input logic co, input logic [2:0] egl);
    send(op, a, b);
    wait_rsp(cyc, busy_ok);
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_busy"}, busy_ok, 1'b1);
    chk({tag, "_rd"}, rsp_rd, rd);
    chk({tag, "_co"}, rsp_co, co);
    chk({tag, "_eq_gt_lt"}, {rsp_eq, rsp_gt, rsp_lt}, egl);
    take();
  endtask
  initial begin
    #2;
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_rd", rsp_rd, 32'h0);
    chk("reset_flags", {rsp_co, rsp_eq, rsp_gt, rsp_lt}, 4'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_req_ready", req_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_rsp_ready_ignored", {rsp_valid, busy, req_ready}, 3'b001);
    op_check("add_ffff_1", OP_ADD, 16'hFFFF, 16'h0001, 2, 32'h0, 1'b1, 3'b000);
    op_check("add_0_0", OP_ADD, 16'h0000, 16'h0000, 2, 32'h0, 1'b0, 3'b000);
    op_check("sub_5_7", OP_SUB, 16'd5, 16'd7, 2, 32'h0000_FFFE, 1'b1, 3'b000);
    op_check("sub_7_5", OP_SUB, 16'd7, 16'd5, 2, 32'h2, 1'b0, 3'b000);
    op_check("mul_ffff_ffff", OP_MUL, 16'hFFFF, 16'hFFFF, 17, 32'hFFFE_0001, 1'b0, 3'b000);
    op_check("mul_0_ffff", OP_MUL, 16'h0000, 16'hFFFF, 17, 32'h0, 1'b0, 3'b000);
    op_check("cmp_100_200", OP_CMP, 16'd100, 16'd200, 2, 32'h0, 1'b0, 3'b001);
    op_check("cmp_7_7", OP_CMP, 16'd7, 16'd7, 2, 32'h0, 1'b0, 3'b100);
    op_check("cmp_9_3", OP_CMP, 16'd9, 16'd3, 2, 32'h0, 1'b0, 3'b010);
    send(OP_MUL, 16'd3, 16'd4);
    wait_rsp(cyc, busy_ok);
    chk("stall_latency", cyc, 17);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid = 1'b1;
        req_op = OP_ADD;
        req_rs1 = 16'd1;
        req_rs2 = 16'd1;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_rd", rsp_rd, 32'd12);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    take();
    repeat (3) @(negedge clk);
    chk("stall_add_not_accepted", {rsp_valid, busy}, 2'b00);
    send(OP_MUL, 16'd1234, 16'd567);
    repeat (7) @(negedge clk);
    chk("mid_mul_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", rsp_valid, 1'b0);
    chk("abort_rd", rsp_rd, 32'h0);
    chk("abort_flags", {rsp_co, rsp_eq, rsp_gt, rsp_lt, busy}, 5'b0);
    chk("abort_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    op_check("mul_after_abort", OP_MUL, 16'd3, 16'd4, 17, 32'd12, 1'b0, 3'b000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
